// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: FSM states, operand-forward
// select codes and default sizing.
package hazard_ctrl_pkg;

   localparam int REG_ADDR_WIDTH_DEF = 5;
   localparam int MAX_WAIT_DEF       = 15;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FREEZE = 2'd1,
      ST_DRAIN  = 2'd2
   } hz_state_e;

   typedef enum logic [1:0] {
      FWD_RF   = 2'b00,
      FWD_ALU  = 2'b01,
      FWD_DMEM = 2'b10
   } fwd_sel_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle. The pipeline side uses the master
// modport; the hazard controller uses the slave modport.
interface hazard_ctrl_if
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
   parameter int CNT_WIDTH      = 32
);

   logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1, IF_ID_rs2;
   logic                      id_use_rs1, id_use_rs2;
   logic [REG_ADDR_WIDTH-1:0] ID_EX_rd, EX_MEM_rd, MEM_WB_rd;
   logic                      ID_EX_reg_wr_en, EX_MEM_reg_wr_en, EX_MEM_mem_rd, MEM_WB_reg_wr_en;
   logic                      pc_sel_in, imem_ready, dmem_busy;

   logic                      pc_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_bubble;
   logic                      pipe_freeze, bus_err;
   logic [1:0]                forward_comp1, forward_comp2;
   logic [CNT_WIDTH-1:0]      stall_cnt, flush_cnt;

   modport master (
      output IF_ID_rs1, IF_ID_rs2, id_use_rs1, id_use_rs2,
             ID_EX_rd, ID_EX_reg_wr_en, EX_MEM_rd, EX_MEM_reg_wr_en, EX_MEM_mem_rd,
             MEM_WB_rd, MEM_WB_reg_wr_en, pc_sel_in, imem_ready, dmem_busy,
      input  pc_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_bubble, pipe_freeze,
             forward_comp1, forward_comp2, bus_err, stall_cnt, flush_cnt
   );

   modport slave (
      input  IF_ID_rs1, IF_ID_rs2, id_use_rs1, id_use_rs2,
             ID_EX_rd, ID_EX_reg_wr_en, EX_MEM_rd, EX_MEM_reg_wr_en, EX_MEM_mem_rd,
             MEM_WB_rd, MEM_WB_reg_wr_en, pc_sel_in, imem_ready, dmem_busy,
      output pc_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_bubble, pipe_freeze,
             forward_comp1, forward_comp2, bus_err, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/hazard_ctrl_match.sv
// Per-operand dependency check: forward select for the ID operand and the
// load-use / write-back stall request for that operand.
module hazard_match
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
   input  logic [REG_ADDR_WIDTH-1:0] rs_i,
   input  logic                      use_i,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
   input  logic                      ex_wr_i,
   input  logic [REG_ADDR_WIDTH-1:0] mem_rd_i,
   input  logic                      mem_wr_i,
   input  logic                      mem_load_i,
   input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
   input  logic                      wb_wr_i,
   output logic [1:0]                fwd_o,
   output logic                      stall_o
);

   logic hit_ex, hit_mem, hit_wb;

   // x0 is hardwired to zero, so a write to it never creates a dependency.
   assign hit_ex  = use_i && ex_wr_i  && (ex_rd_i  == rs_i) && (ex_rd_i  != '0);
   assign hit_mem = use_i && mem_wr_i && (mem_rd_i == rs_i) && (mem_rd_i != '0);
   assign hit_wb  = use_i && wb_wr_i  && (wb_rd_i  == rs_i) && (wb_rd_i  != '0);

   assign fwd_o   = !hit_mem ? FWD_RF : (mem_load_i ? FWD_DMEM : FWD_ALU);

   // MEM holds the younger write, so a MEM hit supersedes the WB one.
   assign stall_o = hit_ex || (hit_wb && !hit_mem);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/freeze arbitration, ID forwarding
// and data-memory timeout. Optional counters enabled by HAZARD_PERF_CNT_EN.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
   parameter int MAX_WAIT       = MAX_WAIT_DEF,
   parameter int CNT_WIDTH      = 32
) (
   input logic          clk,
   input logic          reset_n,
   hazard_ctrl_if.slave bus
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   logic              stall_rs1, stall_rs2, haz_stall, freeze;
   hz_state_e         state_q;
   logic [WAIT_W-1:0] wait_q;
   logic              bus_err_q;
   logic              pc_wr_en_c, if_id_wr_en_c, if_id_flush_c, id_ex_bubble_c;

   hazard_match #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_match_rs1 (
      .rs_i      (bus.IF_ID_rs1),       .use_i   (bus.id_use_rs1),
      .ex_rd_i   (bus.ID_EX_rd),        .ex_wr_i (bus.ID_EX_reg_wr_en),
      .mem_rd_i  (bus.EX_MEM_rd),       .mem_wr_i(bus.EX_MEM_reg_wr_en),
      .mem_load_i(bus.EX_MEM_mem_rd),
      .wb_rd_i   (bus.MEM_WB_rd),       .wb_wr_i (bus.MEM_WB_reg_wr_en),
      .fwd_o     (bus.forward_comp1),   .stall_o (stall_rs1)
   );

   hazard_match #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_match_rs2 (
      .rs_i      (bus.IF_ID_rs2),       .use_i   (bus.id_use_rs2),
      .ex_rd_i   (bus.ID_EX_rd),        .ex_wr_i (bus.ID_EX_reg_wr_en),
      .mem_rd_i  (bus.EX_MEM_rd),       .mem_wr_i(bus.EX_MEM_reg_wr_en),
      .mem_load_i(bus.EX_MEM_mem_rd),
      .wb_rd_i   (bus.MEM_WB_rd),       .wb_wr_i (bus.MEM_WB_reg_wr_en),
      .fwd_o     (bus.forward_comp2),   .stall_o (stall_rs2)
   );

   assign haz_stall = stall_rs1 || stall_rs2;
   assign freeze    = bus.dmem_busy && (state_q != ST_DRAIN);

   // FREEZE exits to DRAIN on the busy cycle that completes MAX_WAIT frozen
   // cycles, so the pipeline is released instead of frozen a further cycle.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_RUN;
         wait_q    <= '0;
         bus_err_q <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (bus.dmem_busy) begin
                  wait_q <= WAIT_W'(1);
                  if (MAX_WAIT <= 1) begin
                     state_q   <= ST_DRAIN;
                     bus_err_q <= 1'b1;
                  end else begin
                     state_q <= ST_FREEZE;
                  end
               end
            end
            ST_FREEZE: begin
               if (!bus.dmem_busy) begin
                  state_q <= ST_RUN;
               end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                  state_q   <= ST_DRAIN;
                  wait_q    <= WAIT_W'(MAX_WAIT);
                  bus_err_q <= 1'b1;
               end else begin
                  wait_q <= wait_q + WAIT_W'(1);
               end
            end
            ST_DRAIN: begin
               if (!bus.dmem_busy) state_q <= ST_RUN;
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   // NOTE: every output gets a default first so no path through the
   // priority chain can leave one unassigned and infer a latch.
   always_comb begin
      pc_wr_en_c      = 1'b1;
      if_id_wr_en_c   = 1'b1;
      if_id_flush_c   = 1'b0;
      id_ex_bubble_c  = 1'b0;
      if (freeze) begin
         pc_wr_en_c     = 1'b0;
         if_id_wr_en_c  = 1'b0;
      end else if (haz_stall) begin
         pc_wr_en_c     = 1'b0;
         if_id_wr_en_c  = 1'b0;
         id_ex_bubble_c = 1'b1;
      end else if (bus.pc_sel_in) begin
         if_id_flush_c  = 1'b1;
      end else if (!bus.imem_ready) begin
         pc_wr_en_c     = 1'b0;
         if_id_flush_c  = 1'b1;
      end
   end

   assign bus.pc_wr_en     = pc_wr_en_c;
   assign bus.IF_ID_wr_en  = if_id_wr_en_c;
   assign bus.IF_ID_flush  = if_id_flush_c;
   assign bus.ID_EX_bubble = id_ex_bubble_c;
   assign bus.pipe_freeze  = freeze;
   assign bus.bus_err      = bus_err_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic                 redirect;

   assign redirect = bus.pc_sel_in && !freeze && !haz_stall;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (id_ex_bubble_c && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      if (redirect && !(&flush_cnt_q))       flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
`else
   assign bus.stall_cnt = {CNT_WIDTH{1'b0}};
   assign bus.flush_cnt = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed cases plus randomized traffic
// compared every cycle against a rule-level reference model.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   localparam int AW   = 5;
   localparam int MW   = 15;
   localparam int CW   = 6;
   localparam int MAXC = (1 << CW) - 1;
`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   bit   chk_on  = 1'b0;
   int   n_cmp   = 0;
   int   n_err   = 0;

   always #5 clk = ~clk;

   hazard_ctrl_if #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

   hazard_ctrl #(.REG_ADDR_WIDTH(AW), .MAX_WAIT(MW), .CNT_WIDTH(CW)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int run_q;    // consecutive busy cycles completed before the current one
   bit err_m;
   int stall_m, flush_m;

   function automatic bit hit(input bit use_, input logic [AW-1:0] rs,
                              input bit wr, input logic [AW-1:0] rd);
      return use_ && wr && (rd == rs) && (rd != 0);
   endfunction

   function automatic logic [1:0] exp_fwd(input bit use_, input logic [AW-1:0] rs);
      if (!hit(use_, rs, bus.EX_MEM_reg_wr_en, bus.EX_MEM_rd)) return 2'b00;
      return bus.EX_MEM_mem_rd ? 2'b10 : 2'b01;
   endfunction

   function automatic bit exp_haz();
      bit              u[2];
      logic [AW-1:0]   r[2];
      bit              s;
      u[0] = bus.id_use_rs1; r[0] = bus.IF_ID_rs1;
      u[1] = bus.id_use_rs2; r[1] = bus.IF_ID_rs2;
      s = 1'b0;
      for (int k = 0; k < 2; k++)
         s |= hit(u[k], r[k], bus.ID_EX_reg_wr_en, bus.ID_EX_rd) ||
              (hit(u[k], r[k], bus.MEM_WB_reg_wr_en, bus.MEM_WB_rd) &&
               !hit(u[k], r[k], bus.EX_MEM_reg_wr_en, bus.EX_MEM_rd));
      return s;
   endfunction

   // A busy episode freezes the pipe for at most MW cycles.
   function automatic bit exp_freeze();
      return bus.dmem_busy && (run_q < MW);
   endfunction

   // {pc_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_bubble}
   function automatic logic [3:0] exp_ctrl();
      if (exp_freeze())     return 4'b0000;
      if (exp_haz())        return 4'b0001;
      if (bus.pc_sel_in)    return 4'b1110;
      if (!bus.imem_ready)  return 4'b0110;
      return 4'b1100;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run_q   <= 0;
         err_m   <= 1'b0;
         stall_m <= 0;
         flush_m <= 0;
      end else begin
         if (bus.dmem_busy) begin
            run_q <= (run_q < 1000) ? run_q + 1 : run_q;
            if (run_q + 1 == MW) err_m <= 1'b1;
         end else begin
            run_q <= 0;
         end
         if (exp_ctrl() == 4'b0001 && stall_m < MAXC) stall_m <= stall_m + 1;
         if (exp_ctrl() == 4'b1110 && flush_m < MAXC) flush_m <= flush_m + 1;
      end
   end

   logic [3:0] exp_c;
   always @(negedge clk) begin
      if (reset_n && chk_on) begin
         exp_c = exp_ctrl();
         check("pc_wr_en",      bus.pc_wr_en,      exp_c[3]);
         check("IF_ID_wr_en",   bus.IF_ID_wr_en,   exp_c[2]);
         check("IF_ID_flush",   bus.IF_ID_flush,   exp_c[1]);
         check("ID_EX_bubble",  bus.ID_EX_bubble,  exp_c[0]);
         check("pipe_freeze",   bus.pipe_freeze,   exp_freeze());
         check("forward_comp1", bus.forward_comp1, exp_fwd(bus.id_use_rs1, bus.IF_ID_rs1));
         check("forward_comp2", bus.forward_comp2, exp_fwd(bus.id_use_rs2, bus.IF_ID_rs2));
         check("bus_err",       bus.bus_err,       err_m);
         check("stall_cnt",     bus.stall_cnt,     PERF ? stall_m : 0);
         check("flush_cnt",     bus.flush_cnt,     PERF ? flush_m : 0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic clear_inputs();
      bus.IF_ID_rs1 = '0;  bus.IF_ID_rs2 = '0;
      bus.id_use_rs1 = 0;  bus.id_use_rs2 = 0;
      bus.ID_EX_rd = '0;   bus.ID_EX_reg_wr_en = 0;
      bus.EX_MEM_rd = '0;  bus.EX_MEM_reg_wr_en = 0; bus.EX_MEM_mem_rd = 0;
      bus.MEM_WB_rd = '0;  bus.MEM_WB_reg_wr_en = 0;
      bus.pc_sel_in = 0;   bus.imem_ready = 1;     bus.dmem_busy = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int busy_left;

   initial begin
      clear_inputs();
      #1 reset_n = 1'b0;
      #2;
      check("rst_bus_err",   bus.bus_err,     0);
      check("rst_freeze",    bus.pipe_freeze, 0);
      check("rst_stall_cnt", bus.stall_cnt,   0);
      check("rst_flush_cnt", bus.flush_cnt,   0);
      check("rst_pc_wr_en",  bus.pc_wr_en,    1);
      tick(); tick();
      reset_n = 1'b1;
      chk_on  = 1'b1;

      // Case 1: EX-stage dependency stalls, then forwards from ALU
      bus.ID_EX_rd = 5; bus.ID_EX_reg_wr_en = 1; bus.IF_ID_rs1 = 5; bus.id_use_rs1 = 1;
      #1;
      check("c1_bubble", bus.ID_EX_bubble, 1);
      check("c1_pc_wr",  bus.pc_wr_en,     0);
      tick();
      bus.ID_EX_reg_wr_en = 0; bus.EX_MEM_rd = 5; bus.EX_MEM_reg_wr_en = 1;
      #1;
      check("c1_fwd1",      bus.forward_comp1, 2'b01);
      check("c1_no_bubble", bus.ID_EX_bubble,  0);
      tick();

      // Case 2: load in MEM forwards DMEM data; rd=0 never forwards
      clear_inputs();
      bus.EX_MEM_rd = 6; bus.EX_MEM_reg_wr_en = 1; bus.EX_MEM_mem_rd = 1;
      bus.IF_ID_rs2 = 6; bus.id_use_rs2 = 1;
      #1;
      check("c2_fwd2_dmem", bus.forward_comp2, 2'b10);
      check("c2_no_stall",  bus.ID_EX_bubble,  0);
      tick();
      bus.EX_MEM_rd = 0; bus.IF_ID_rs2 = 0;
      #1;
      check("c2_fwd2_x0",   bus.forward_comp2, 2'b00);
      check("c2_x0_stall",  bus.ID_EX_bubble,  0);
      tick();

      // Case 3: stall suppresses redirect; clean redirect flushes regardless of imem_ready
      clear_inputs();
      bus.pc_sel_in = 1; bus.ID_EX_rd = 3; bus.ID_EX_reg_wr_en = 1;
      bus.IF_ID_rs1 = 3; bus.id_use_rs1 = 1;
      #1;
      check("c3_flush_masked", bus.IF_ID_flush,  0);
      check("c3_bubble",       bus.ID_EX_bubble, 1);
      tick();
      clear_inputs();
      bus.pc_sel_in = 1; bus.imem_ready = 0;
      #1;
      check("c3_flush",  bus.IF_ID_flush, 1);
      check("c3_pc_wr",  bus.pc_wr_en,    1);
      tick();
      bus.pc_sel_in = 0;
      #1;
      check("c3_fetch_wait_pc",    bus.pc_wr_en,    0);
      check("c3_fetch_wait_flush", bus.IF_ID_flush, 1);
      check("c3_flush_cnt",        bus.flush_cnt,   PERF ? 1 : 0);
      check("c3_stall_cnt",        bus.stall_cnt,   PERF ? 2 : 0);
      tick();

      // Case 4: WB dependency stalls unless MEM also matches
      clear_inputs();
      bus.MEM_WB_rd = 7; bus.MEM_WB_reg_wr_en = 1; bus.IF_ID_rs1 = 7; bus.id_use_rs1 = 1;
      #1;
      check("c4_wb_stall", bus.ID_EX_bubble, 1);
      tick();
      bus.EX_MEM_rd = 7; bus.EX_MEM_reg_wr_en = 1;
      #1;
      check("c4_no_stall", bus.ID_EX_bubble,  0);
      check("c4_fwd1",     bus.forward_comp1, 2'b01);
      tick();
      bus.id_use_rs1 = 0;
      #1;
      check("c4_unused_fwd", bus.forward_comp1, 2'b00);
      tick();

      // Case 5: busy held 20 cycles -> 15 frozen, then bus error
      clear_inputs();
      for (int i = 1; i <= 20; i++) begin
         bus.dmem_busy = 1;
         #1;
         check("c5_freeze",  bus.pipe_freeze, (i <= MW) ? 1 : 0);
         check("c5_bus_err", bus.bus_err,     (i >  MW) ? 1 : 0);
         tick();
      end
      bus.dmem_busy = 0;
      #1;
      check("c5_drop_freeze", bus.pipe_freeze, 0);
      tick();
      bus.dmem_busy = 1;
      #1;
      check("c5_refreeze",    bus.pipe_freeze, 1);
      check("c5_err_sticky",  bus.bus_err,     1);
      tick();

      // Case 6: async reset mid-freeze clears everything without a clock edge
      #1;
      reset_n = 1'b0; bus.dmem_busy = 0;
      #1;
      check("c6_freeze",    bus.pipe_freeze, 0);
      check("c6_bus_err",   bus.bus_err,     0);
      check("c6_stall_cnt", bus.stall_cnt,   0);
      check("c6_flush_cnt", bus.flush_cnt,   0);
      tick(); tick();
      reset_n = 1'b1;
      tick();

      // Randomized traffic; small register range keeps dependencies frequent
      busy_left = 0;
      for (int c = 0; c < 3000; c++) begin
         bus.IF_ID_rs1        = AW'($urandom_range(0, 3));
         bus.IF_ID_rs2        = AW'($urandom_range(0, 3));
         bus.id_use_rs1       = ($urandom_range(0, 3) != 0);
         bus.id_use_rs2       = ($urandom_range(0, 3) != 0);
         bus.ID_EX_rd         = AW'($urandom_range(0, 3));
         bus.ID_EX_reg_wr_en  = ($urandom_range(0, 3) == 0);
         bus.EX_MEM_rd        = AW'($urandom_range(0, 3));
         bus.EX_MEM_reg_wr_en = $urandom_range(0, 1);
         bus.EX_MEM_mem_rd    = $urandom_range(0, 1);
         bus.MEM_WB_rd        = AW'($urandom_range(0, 3));
         bus.MEM_WB_reg_wr_en = $urandom_range(0, 1);
         bus.pc_sel_in        = ($urandom_range(0, 4) == 0);
         bus.imem_ready       = ($urandom_range(0, 4) != 0);
         if (busy_left > 0) begin
            bus.dmem_busy = 1;
            busy_left--;
         end else if ($urandom_range(0, 15) == 0) begin
            bus.dmem_busy = 1;
            busy_left = $urandom_range(0, 21);
         end else begin
            bus.dmem_busy = 0;
         end
         tick();
      end

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
